// File: rtl/mem_arb_pkg.sv
// Shared types and owner codes for the memory arbiter and its requesters.
// Optional build macro: MEM_ARB_RR_EN selects CPU/SPART round-robin instead of fixed priority.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } arb_state_t;

   // Ownership codes published on mem_busy; requesters decode the same values.
   localparam logic [1:0] BUSY_IDLE  = 2'b00;
   localparam logic [1:0] BUSY_CPU   = 2'b01;
   localparam logic [1:0] BUSY_SPART = 2'b10;
   localparam logic [1:0] BUSY_AUD   = 2'b11;

   // Bit positions inside the one-hot winner vector.
   localparam int unsigned WIN_CPU   = 0;
   localparam int unsigned WIN_SPART = 1;
   localparam int unsigned WIN_AUD   = 2;

   // Round-robin pointer values: which of CPU/SPART is favoured next.
   localparam logic RR_CPU   = 1'b0;
   localparam logic RR_SPART = 1'b1;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selection for the memory arbiter.
// Audio always wins; CPU vs SPART is round-robin when MEM_ARB_RR_EN is
// defined, otherwise CPU has fixed priority over SPART.
module mem_arb_pick
   import mem_arb_pkg::*;
(
   input  logic       cpu_req,
   input  logic       spart_req,
   input  logic       aud_req,
`ifdef MEM_ARB_RR_EN
   input  logic       rr_ptr,
`endif
   output logic [2:0] win,
   output logic [1:0] code
);

   // Pick exactly one requester (or none) and report its owner code.
   always_comb begin
      win  = 3'b000;
      code = BUSY_IDLE;
      if (aud_req) begin
         win[WIN_AUD] = 1'b1;
         code         = BUSY_AUD;
      end
`ifdef MEM_ARB_RR_EN
      else if (cpu_req && (!spart_req || rr_ptr == RR_CPU)) begin
         win[WIN_CPU] = 1'b1;
         code         = BUSY_CPU;
      end
`else
      else if (cpu_req) begin
         win[WIN_CPU] = 1'b1;
         code         = BUSY_CPU;
      end
`endif
      else if (spart_req) begin
         win[WIN_SPART] = 1'b1;
         code           = BUSY_SPART;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Shared memory port arbiter for CPU, SPART and audio.
// One transaction at a time: IDLE -> ISSUE -> WAIT (until mem_ack) -> RESP.
// All outputs are registered. Build macro MEM_ARB_RR_EN enables CPU/SPART
// round-robin; without it priority is fixed audio > CPU > SPART.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int AW = 32,
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          cpu_req,
   input  logic          spart_req,
   input  logic          aud_req,
   input  logic          cpu_we,
   input  logic          spart_we,
   input  logic          aud_we,
   input  logic [AW-1:0] cpu_addr,
   input  logic [AW-1:0] spart_addr,
   input  logic [AW-1:0] aud_addr,
   input  logic [DW-1:0] cpu_wdata,
   input  logic [DW-1:0] spart_wdata,
   input  logic [DW-1:0] aud_wdata,
   output logic          cpu_gnt,
   output logic          spart_gnt,
   output logic          aud_gnt,
   output logic          cpu_done,
   output logic          spart_done,
   output logic          aud_done,
   output logic [DW-1:0] rdata,
   output logic [1:0]    mem_busy,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   input  logic          mem_ack
);

   arb_state_t    state;
   logic [2:0]    win;
   logic [1:0]    win_code;
   logic          sel_we;
   logic [AW-1:0] sel_addr;
   logic [DW-1:0] sel_wdata;

`ifdef MEM_ARB_RR_EN
   logic          rr_ptr;
`endif

   mem_arb_pick u_pick (
      .cpu_req   (cpu_req),
      .spart_req (spart_req),
      .aud_req   (aud_req),
`ifdef MEM_ARB_RR_EN
      .rr_ptr    (rr_ptr),
`endif
      .win       (win),
      .code      (win_code)
   );

   // Route the winner's command fields toward the memory-side registers.
   always_comb begin
      sel_we    = 1'b0;
      sel_addr  = '0;
      sel_wdata = '0;
      if (win[WIN_AUD]) begin
         sel_we    = aud_we;
         sel_addr  = aud_addr;
         sel_wdata = aud_wdata;
      end else if (win[WIN_CPU]) begin
         sel_we    = cpu_we;
         sel_addr  = cpu_addr;
         sel_wdata = cpu_wdata;
      end else if (win[WIN_SPART]) begin
         sel_we    = spart_we;
         sel_addr  = spart_addr;
         sel_wdata = spart_wdata;
      end
   end

   // Transaction sequencer; the owner code in mem_busy doubles as the
   // latched winner used to route the completion pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         cpu_gnt    <= 1'b0;
         spart_gnt  <= 1'b0;
         aud_gnt    <= 1'b0;
         cpu_done   <= 1'b0;
         spart_done <= 1'b0;
         aud_done   <= 1'b0;
         rdata      <= '0;
         mem_busy   <= BUSY_IDLE;
         mem_en     <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
      end else begin
         cpu_gnt    <= 1'b0;
         spart_gnt  <= 1'b0;
         aud_gnt    <= 1'b0;
         cpu_done   <= 1'b0;
         spart_done <= 1'b0;
         aud_done   <= 1'b0;
         mem_en     <= 1'b0;
         unique case (state)
            ST_IDLE: begin
               if (|win) begin
                  state     <= ST_ISSUE;
                  mem_en    <= 1'b1;
                  mem_we    <= sel_we;
                  mem_addr  <= sel_addr;
                  mem_wdata <= sel_wdata;
                  mem_busy  <= win_code;
                  cpu_gnt   <= win[WIN_CPU];
                  spart_gnt <= win[WIN_SPART];
                  aud_gnt   <= win[WIN_AUD];
               end
            end
            ST_ISSUE: begin
               // Write enable is only meaningful alongside the issue strobe.
               mem_we <= 1'b0;
               state  <= ST_WAIT;
            end
            ST_WAIT: begin
               if (mem_ack) begin
                  rdata      <= mem_rdata;
                  cpu_done   <= (mem_busy == BUSY_CPU);
                  spart_done <= (mem_busy == BUSY_SPART);
                  aud_done   <= (mem_busy == BUSY_AUD);
                  state      <= ST_RESP;
               end
            end
            ST_RESP: begin
               mem_busy <= BUSY_IDLE;
               state    <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

`ifdef MEM_ARB_RR_EN
   // Point at the other CPU/SPART requester after each CPU or SPART grant.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr <= RR_CPU;
      end else if (state == ST_IDLE && (win[WIN_CPU] || win[WIN_SPART])) begin
         rr_ptr <= win[WIN_CPU] ? RR_SPART : RR_CPU;
      end
   end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter with a latency-programmable memory model.
// Expected CPU/SPART ordering follows MEM_ARB_RR_EN when it is defined.
module tb_mem_arbiter;
   import mem_arb_pkg::*;

   localparam int AW = 32;
   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          cpu_req = 1'b0, spart_req = 1'b0, aud_req = 1'b0;
   logic          cpu_we = 1'b0, spart_we = 1'b0, aud_we = 1'b0;
   logic [AW-1:0] cpu_addr = '0, spart_addr = '0, aud_addr = '0;
   logic [DW-1:0] cpu_wdata = '0, spart_wdata = '0, aud_wdata = '0;
   logic          cpu_gnt, spart_gnt, aud_gnt;
   logic          cpu_done, spart_done, aud_done;
   logic [DW-1:0] rdata;
   logic [1:0]    mem_busy;
   logic          mem_en, mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata = '0;
   logic          mem_ack;
   logic          model_ack = 1'b0;
   logic          spur_ack = 1'b0;

   int lat = 1;
   int mem_cnt = 0;
   int vectors = 0;
   int miscompares = 0;

   assign mem_ack = model_ack | spur_ack;

   always #5 clk = ~clk;

   mem_arbiter #(.AW(AW), .DW(DW)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .cpu_req     (cpu_req),
      .spart_req   (spart_req),
      .aud_req     (aud_req),
      .cpu_we      (cpu_we),
      .spart_we    (spart_we),
      .aud_we      (aud_we),
      .cpu_addr    (cpu_addr),
      .spart_addr  (spart_addr),
      .aud_addr    (aud_addr),
      .cpu_wdata   (cpu_wdata),
      .spart_wdata (spart_wdata),
      .aud_wdata   (aud_wdata),
      .cpu_gnt     (cpu_gnt),
      .spart_gnt   (spart_gnt),
      .aud_gnt     (aud_gnt),
      .cpu_done    (cpu_done),
      .spart_done  (spart_done),
      .aud_done    (aud_done),
      .rdata       (rdata),
      .mem_busy    (mem_busy),
      .mem_en      (mem_en),
      .mem_we      (mem_we),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .mem_rdata   (mem_rdata),
      .mem_ack     (mem_ack)
   );

   // Memory model: ack arrives L cycles after the cycle that carries mem_en.
   always @(posedge clk) begin
      #1;
      model_ack = 1'b0;
      if (mem_cnt > 0) begin
         mem_cnt = mem_cnt - 1;
         if (mem_cnt == 0) model_ack = 1'b1;
      end
      if (mem_en) mem_cnt = lat;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   function automatic logic [31:0] gnt_vec();
      return {29'd0, aud_gnt, spart_gnt, cpu_gnt};
   endfunction

   function automatic logic [31:0] done_vec();
      return {29'd0, aud_done, spart_done, cpu_done};
   endfunction

   // Runs one transaction whose request is already presented in the current cycle.
   task automatic txn(input string tag, input logic [1:0] code, input int l,
                      input logic [31:0] rd, input bit drop, input logic we,
                      input logic [31:0] addr, input logic [31:0] wd);
      int          n;
      logic [31:0] oh;
      lat       = l;
      mem_rdata = rd;
      oh = (code == BUSY_CPU) ? 32'd1 : (code == BUSY_SPART) ? 32'd2 : 32'd4;
      tick();
      chk({tag, ".gnt"},   gnt_vec(), oh);
      chk({tag, ".busy"},  32'(mem_busy), 32'(code));
      chk({tag, ".en"},    32'(mem_en), 32'd1);
      chk({tag, ".we"},    32'(mem_we), 32'(we));
      chk({tag, ".addr"},  mem_addr, addr);
      chk({tag, ".wdata"}, mem_wdata, wd);
      if (drop) begin
         if (code == BUSY_CPU)   cpu_req   = 1'b0;
         if (code == BUSY_SPART) spart_req = 1'b0;
         if (code == BUSY_AUD)   aud_req   = 1'b0;
      end
      n = 0;
      do begin
         tick();
         n++;
         chk({tag, ".hold"}, 32'(mem_busy), 32'(code));
      end while (!(cpu_done | spart_done | aud_done) && n < l + 6);
      chk({tag, ".lat"},  n, l + 1);
      chk({tag, ".done"}, done_vec(), oh);
      chk({tag, ".en0"},  32'(mem_en), 32'd0);
      if (!we) chk({tag, ".rdata"}, rdata, rd);
      tick();
      chk({tag, ".idle"},  32'(mem_busy), 32'(BUSY_IDLE));
      chk({tag, ".done0"}, done_vec(), 32'd0);
   endtask

   initial begin
      int dones;
      int busy_seen;

      // Reset state
      tick();
      tick();
      chk("rst.gnt",   gnt_vec(), 32'd0);
      chk("rst.done",  done_vec(), 32'd0);
      chk("rst.busy",  32'(mem_busy), 32'd0);
      chk("rst.en",    32'(mem_en), 32'd0);
      chk("rst.we",    32'(mem_we), 32'd0);
      chk("rst.addr",  mem_addr, 32'd0);
      chk("rst.wdata", mem_wdata, 32'd0);
      chk("rst.rdata", rdata, 32'd0);
      rst_n = 1'b1;
      tick();

      // Audio read, L=1
      aud_req  = 1'b1;
      aud_addr = 32'h20;
      txn("aud_rd", BUSY_AUD, 1, 32'hDEADBEEF, 1'b1, 1'b0, 32'h20, 32'h0);

      // All three at once: audio, then CPU, then SPART
      aud_addr   = 32'h24;
      cpu_addr   = 32'h40;
      spart_addr = 32'h80;
      aud_req    = 1'b1;
      cpu_req    = 1'b1;
      spart_req  = 1'b1;
      txn("all_aud",   BUSY_AUD,   1, 32'h11111111, 1'b1, 1'b0, 32'h24, 32'h0);
      txn("all_cpu",   BUSY_CPU,   1, 32'h22222222, 1'b1, 1'b0, 32'h40, 32'h0);
      txn("all_spart", BUSY_SPART, 2, 32'h33333333, 1'b1, 1'b0, 32'h80, 32'h0);

      // CPU and SPART held for four transactions
      cpu_req   = 1'b1;
      spart_req = 1'b1;
`ifdef MEM_ARB_RR_EN
      txn("hold1", BUSY_CPU,   1, 32'hA1, 1'b0, 1'b0, 32'h40, 32'h0);
      txn("hold2", BUSY_SPART, 1, 32'hA2, 1'b0, 1'b0, 32'h80, 32'h0);
      txn("hold3", BUSY_CPU,   1, 32'hA3, 1'b0, 1'b0, 32'h40, 32'h0);
      txn("hold4", BUSY_SPART, 1, 32'hA4, 1'b0, 1'b0, 32'h80, 32'h0);
`else
      txn("hold1", BUSY_CPU, 1, 32'hA1, 1'b0, 1'b0, 32'h40, 32'h0);
      txn("hold2", BUSY_CPU, 1, 32'hA2, 1'b0, 1'b0, 32'h40, 32'h0);
      txn("hold3", BUSY_CPU, 1, 32'hA3, 1'b0, 1'b0, 32'h40, 32'h0);
      txn("hold4", BUSY_CPU, 1, 32'hA4, 1'b0, 1'b0, 32'h40, 32'h0);
`endif
      cpu_req   = 1'b0;
      spart_req = 1'b0;
      tick();

      // CPU write, L=5
      cpu_req   = 1'b1;
      cpu_we    = 1'b1;
      cpu_addr  = 32'h100;
      cpu_wdata = 32'h12345678;
      txn("cpu_wr", BUSY_CPU, 5, 32'hCAFEF00D, 1'b1, 1'b1, 32'h100, 32'h12345678);
      cpu_we = 1'b0;

      // Reset during WAIT aborts the transaction; the late ack is ignored
      lat       = 6;
      mem_rdata = 32'h77777777;
      cpu_req   = 1'b1;
      cpu_addr  = 32'h200;
      tick();
      chk("abort.gnt", gnt_vec(), 32'd1);
      cpu_req = 1'b0;
      tick();
      tick();
      chk("abort.wait_busy", 32'(mem_busy), 32'(BUSY_CPU));
      #1 rst_n = 1'b0;
      #1;
      chk("abort.busy",  32'(mem_busy), 32'd0);
      chk("abort.addr",  mem_addr, 32'd0);
      chk("abort.rdata", rdata, 32'd0);
      chk("abort.done",  done_vec(), 32'd0);
      #3 rst_n = 1'b1;
      dones     = 0;
      busy_seen = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (cpu_done | spart_done | aud_done) dones++;
         if (mem_busy != BUSY_IDLE || mem_en) busy_seen++;
      end
      chk("abort.no_done", dones, 0);
      chk("abort.no_busy", busy_seen, 0);

      // Spurious ack while idle
      spur_ack = 1'b1;
      tick();
      spur_ack = 1'b0;
      tick();
      chk("spur.busy", 32'(mem_busy), 32'd0);
      chk("spur.done", done_vec(), 32'd0);
      chk("spur.en",   32'(mem_en), 32'd0);
      tick();
      chk("spur.done2", done_vec(), 32'd0);

      // Normal transaction still works afterward
      spart_req  = 1'b1;
      spart_addr = 32'h300;
      txn("spart_after", BUSY_SPART, 1, 32'h5A5A5A5A, 1'b1, 1'b0, 32'h300, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   // Run-time bound
   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

endmodule
